pe_ws_dbuf: RTL

Parametrised weight-stationary processing element for the systolic array, and the successor of the single-weight PE. It adds NBANK weight banks, so the next weight streams in while the current one computes. It also adds configurable data and accumulator widths, a signed/unsigned mode, optional saturating accumulation and a sticky overflow flag. Activations and control ripple to the right neighbour. Accumulators are read by the array drain logic.

---
 rtl/pe_ws_dbuf.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with NBANK double-buffered weight banks, signed/unsigned MAC,
// optional saturating accumulation, sticky overflow/load-error flags and right-neighbour forwarding.
module pe_ws_dbuf #(
  parameter int  DATA_W = 8,
  parameter int  ACC_W  = 32,
  parameter int  NBANK  = 2,
  parameter int  PIPE   = 1,
  parameter int  SAT    = 1,
  localparam int IW     = $clog2(NBANK)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [DATA_W-1:0]        i_a_in,
  input  logic [DATA_W-1:0]        i_b_in,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic                     i_bypass,
  input  logic                     i_is_unsigned,
  input  logic                     i_w_load,
  input  logic [IW-1:0]            i_w_idx,
  input  logic                     i_swap,
  output logic [DATA_W-1:0]        o_a_out,
  output logic                     o_w_load_out,
  output logic [IW-1:0]            o_w_idx_out,
  output logic                     o_swap_out,
  output logic [IW-1:0]            o_act_bank,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_ovf,
  output logic                     o_load_err
);

  localparam int MSB = ACC_W - 1;

  logic [DATA_W-1:0] r_bank [NBANK];
  logic [IW-1:0]     r_act_bank;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic              r_load_err;

  logic [DATA_W-1:0] w_w;
  logic [ACC_W-1:0]  w_a_ext;
  logic [ACC_W-1:0]  w_w_ext;
  logic [ACC_W-1:0]  w_p;
  logic [ACC_W-1:0]  w_base;
  logic [ACC_W-1:0]  w_sum;
  logic [ACC_W-1:0]  w_acc_res;
  logic              w_ovf_op;
  logic              w_conflict;
  logic [IW-1:0]     w_next_bank;

  assign w_w     = r_bank[r_act_bank];
  assign w_a_ext = i_is_unsigned ? {{(ACC_W-DATA_W){1'b0}}, i_a_in}
                                 : {{(ACC_W-DATA_W){i_a_in[DATA_W-1]}}, i_a_in};
  assign w_w_ext = i_is_unsigned ? {{(ACC_W-DATA_W){1'b0}}, w_w}
                                 : {{(ACC_W-DATA_W){w_w[DATA_W-1]}}, w_w};
  // ACC_W >= 2*DATA_W+1 so the truncated product is exact in both modes
  assign w_p     = i_bypass ? w_a_ext : w_a_ext * w_w_ext;

  // clr together with en starts a fresh accumulation from zero
  assign w_base    = i_clr ? '0 : r_acc;
  assign w_sum     = w_base + w_p;
  assign w_ovf_op  = (w_base[MSB] == w_p[MSB]) && (w_sum[MSB] != w_base[MSB]);
  assign w_acc_res = (SAT != 0 && w_ovf_op)
                   ? (w_base[MSB] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                   : w_sum;

  // Conflict uses the pre-swap bank; a write to the bank being read this cycle is dropped
  assign w_conflict  = i_w_load && i_en && (i_w_idx == r_act_bank);
  assign w_next_bank = (r_act_bank == IW'(NBANK-1)) ? '0 : r_act_bank + IW'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NBANK; i++) r_bank[i] <= '0;
      r_act_bank <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      if (i_w_load && !w_conflict) r_bank[i_w_idx] <= i_b_in;
      if (w_conflict)              r_load_err <= 1'b1;
      if (i_swap)                  r_act_bank <= w_next_bank;
      if (i_en) begin
        r_acc <= w_acc_res;
        r_ovf <= i_clr ? w_ovf_op : (r_ovf | w_ovf_op);
      end else if (i_clr) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe
      logic [DATA_W-1:0] r_a_out;
      logic              r_w_load_out;
      logic [IW-1:0]     r_w_idx_out;
      logic              r_swap_out;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_a_out      <= '0;
          r_w_load_out <= 1'b0;
          r_w_idx_out  <= '0;
          r_swap_out   <= 1'b0;
        end else begin
          r_a_out      <= i_a_in;
          r_w_load_out <= i_w_load;
          r_w_idx_out  <= i_w_idx;
          r_swap_out   <= i_swap;
        end
      end
      assign o_a_out      = r_a_out;
      assign o_w_load_out = r_w_load_out;
      assign o_w_idx_out  = r_w_idx_out;
      assign o_swap_out   = r_swap_out;
    end else begin : g_comb
      assign o_a_out      = i_a_in;
      assign o_w_load_out = i_w_load;
      assign o_w_idx_out  = i_w_idx;
      assign o_swap_out   = i_swap;
    end
  endgenerate

  assign o_act_bank = r_act_bank;
  assign o_acc      = r_acc;
  assign o_ovf      = r_ovf;
  assign o_load_err = r_load_err;

endmodule
